// File: rtl/conv_pingpong_sched_if.sv
// Loader / convolution-controller handshake bundle for the ping-pong frame scheduler.
interface conv_pingpong_sched_if #(
  parameter int unsigned M = 7
) ();

  localparam int unsigned FW = 8;

  logic          ld_req;
  logic          ld_wr;
  logic          ld_grant;
  logic          ld_bank;
  logic [M-1:0]  ld_adr;
  logic          conv_start;
  logic          conv_bank;
  logic          conv_avail;
  logic          conv_done;
  logic          busy;
  logic          cnt_err;
  logic [FW-1:0] frame_cnt;

  // Loader and convolution controller side
  modport master (
    output ld_req, ld_wr, conv_avail, conv_done,
    input  ld_grant, ld_bank, ld_adr, conv_start, conv_bank, busy, cnt_err, frame_cnt
  );

  // Scheduler side
  modport slave (
    input  ld_req, ld_wr, conv_avail, conv_done,
    output ld_grant, ld_bank, ld_adr, conv_start, conv_bank, busy, cnt_err, frame_cnt
  );

endinterface

// File: rtl/conv_pingpong_sched.sv
// Ping-pong frame scheduler: overlaps loading of one PxP bank with convolution of the other,
// checks the per-frame output-pixel count and counts completed frames.
module conv_pingpong_sched #(
  parameter int unsigned P = 8,
  parameter int unsigned M = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_pingpong_sched_if.slave  bus
);

  localparam int unsigned FW = 8;
  localparam logic [M-1:0] LAST_ADR = M'(P * P - 1);
  localparam logic [M-1:0] EXP_OUT  = M'((P - 2) * (P - 2));
  localparam logic [M-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_CONV} bank_st_t;
  typedef enum logic       {F_IDLE, F_FILL} fill_st_t;
  typedef enum logic [1:0] {C_IDLE, C_START, C_RUN} conv_st_t;

  fill_st_t      fill_st, fill_nxt;
  conv_st_t      conv_st, conv_nxt;
  bank_st_t      status [2];
  bank_st_t      status_nxt [2];
  logic          wr_ptr, wr_ptr_nxt;
  logic          rd_ptr, rd_ptr_nxt;
  logic [M-1:0]  adr, adr_nxt;
  logic [M-1:0]  out_cnt, out_nxt;
  logic [M-1:0]  out_inc, out_fin;
  logic [FW-1:0] frame_q, frame_nxt;
  logic          err_q, err_nxt;
  logic          grant_q, start_q, busy_q, busy_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_st   <= F_IDLE;
      conv_st   <= C_IDLE;
      status[0] <= B_EMPTY;
      status[1] <= B_EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      adr       <= '0;
      out_cnt   <= '0;
      frame_q   <= '0;
      err_q     <= 1'b0;
      grant_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      fill_st   <= fill_nxt;
      conv_st   <= conv_nxt;
      status[0] <= status_nxt[0];
      status[1] <= status_nxt[1];
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      adr       <= adr_nxt;
      out_cnt   <= out_nxt;
      frame_q   <= frame_nxt;
      err_q     <= err_nxt;
      grant_q   <= (fill_nxt == F_FILL);
      start_q   <= (conv_nxt == C_START);
      busy_q    <= busy_nxt;
    end
  end

  // Next state for both FSMs; they only ever touch different banks in the same cycle
  always_comb begin
    fill_nxt      = fill_st;
    conv_nxt      = conv_st;
    status_nxt[0] = status[0];
    status_nxt[1] = status[1];
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    adr_nxt       = adr;
    out_nxt       = out_cnt;
    frame_nxt     = frame_q;
    err_nxt       = err_q;
    out_inc       = (out_cnt == CNT_MAX) ? out_cnt : out_cnt + M'(1);
    out_fin       = bus.conv_avail ? out_inc : out_cnt;

    case (fill_st)
      F_IDLE: begin
        if (bus.ld_req && (status[wr_ptr] == B_EMPTY)) begin
          fill_nxt           = F_FILL;
          status_nxt[wr_ptr] = B_FILLING;
          adr_nxt            = '0;
        end
      end
      F_FILL: begin
        if (bus.ld_wr) begin
          if (adr == LAST_ADR) begin
            status_nxt[wr_ptr] = B_FULL;
            wr_ptr_nxt         = ~wr_ptr;
            adr_nxt            = '0;
            fill_nxt           = F_IDLE;
          end else begin
            adr_nxt = adr + M'(1);
          end
        end
      end
      default: fill_nxt = F_IDLE;
    endcase

    case (conv_st)
      C_IDLE: begin
        if (status[rd_ptr] == B_FULL) begin
          conv_nxt           = C_START;
          status_nxt[rd_ptr] = B_CONV;
          out_nxt            = '0;
        end
      end
      C_START: conv_nxt = C_RUN;
      C_RUN: begin
        if (bus.conv_done) begin
          status_nxt[rd_ptr] = B_EMPTY;
          rd_ptr_nxt         = ~rd_ptr;
          frame_nxt          = frame_q + FW'(1);
          if (out_fin != EXP_OUT) err_nxt = 1'b1;
          conv_nxt           = C_IDLE;
        end else begin
          out_nxt = out_fin;
        end
      end
      default: conv_nxt = C_IDLE;
    endcase

    busy_nxt = (status_nxt[0] != B_EMPTY) || (status_nxt[1] != B_EMPTY);
  end

  // Output mapping; pointers are stable through a fill or a convolution
  assign bus.ld_grant   = grant_q;
  assign bus.ld_bank    = wr_ptr;
  assign bus.ld_adr     = adr;
  assign bus.conv_start = start_q;
  assign bus.conv_bank  = rd_ptr;
  assign bus.busy       = busy_q;
  assign bus.cnt_err    = err_q;
  assign bus.frame_cnt  = frame_q;

endmodule

// File: tb/tb_conv_pingpong_sched.sv
// Scoreboard bench for conv_pingpong_sched (P=8, M=7): stimulus queues expected writes and
// start pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_conv_pingpong_sched;

  localparam int unsigned P = 8;
  localparam int unsigned M = 7;
  localparam int NPIX = 64;
  localparam int NOUT = 36;

  typedef struct {int cyc; int bank;} start_t;
  typedef struct {int bank; int adr;} wr_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  start_t start_q[$];
  wr_t    wr_q[$];
  start_t se;
  wr_t    we;

  conv_pingpong_sched_if #(.M(M)) bus ();

  conv_pingpong_sched #(.P(P), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every granted write and every start pulse against the queues
  always @(negedge clk) begin
    if (rst) begin
      if (bus.conv_start) begin
        if (start_q.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          se = start_q.pop_front();
          chk("start_cycle", cyc, se.cyc);
          chk("start_bank", int'(bus.conv_bank), se.bank);
        end
      end
      if (bus.ld_wr && bus.ld_grant) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          we = wr_q.pop_front();
          chk("wr_adr", int'(bus.ld_adr), we.adr);
          chk("wr_bank", int'(bus.ld_bank), we.bank);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, int'(bus.ld_grant), 0);
    chk({tag, "_ld_bank"}, int'(bus.ld_bank), 0);
    chk({tag, "_ld_adr"}, int'(bus.ld_adr), 0);
    chk({tag, "_start"}, int'(bus.conv_start), 0);
    chk({tag, "_conv_bank"}, int'(bus.conv_bank), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_cnt_err"}, int'(bus.cnt_err), 0);
    chk({tag, "_frame_cnt"}, int'(bus.frame_cnt), 0);
  endtask

  task automatic do_reset();
    tick();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("start_q_drained", start_q.size(), 0);
    wr_q.delete();
    start_q.delete();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // Request a bank, expect a one-cycle grant latency, then write a full frame
  task automatic do_fill(input int bank, input bit gaps, output int last_cyc);
    int w;
    bus.ld_req = 1'b1;
    tick();
    chk("grant_latency", int'(bus.ld_grant), 1);
    w = 0;
    while (!bus.ld_grant && w < 300) begin
      tick();
      w++;
    end
    if (!bus.ld_grant) chk("grant_timeout", int'(bus.ld_grant), 1);
    bus.ld_req = 1'b0;
    last_cyc = cyc;
    for (int i = 0; i < NPIX; i++) begin
      wr_q.push_back('{bank: bank, adr: i});
      bus.ld_wr = 1'b1;
      last_cyc = cyc;
      tick();
      bus.ld_wr = 1'b0;
      if (gaps && (i % 3 == 1)) tick();
    end
  endtask

  task automatic push_start(input int c, input int bank);
    start_q.push_back('{cyc: c, bank: bank});
  endtask

  // Wait for the start pulse, then step into the run state
  task automatic wait_start();
    int w;
    w = 0;
    while (!bus.conv_start && w < 60) begin
      tick();
      w++;
    end
    if (!bus.conv_start) chk("start_timeout", int'(bus.conv_start), 1);
    tick();
  endtask

  // n avail strobes then a done pulse; merge puts the last avail on the done cycle
  task automatic run_conv(input int n, input bit merge, output int done_cyc);
    for (int i = 0; i < n - (merge ? 1 : 0); i++) begin
      bus.conv_avail = 1'b1;
      tick();
    end
    bus.conv_avail = merge;
    bus.conv_done  = 1'b1;
    done_cyc = cyc;
    tick();
    bus.conv_done  = 1'b0;
    bus.conv_avail = 1'b0;
  endtask

  initial begin
    int last;
    int d;
    int bank;
    rst = 1'b0;
    bus.ld_req = 1'b0;
    bus.ld_wr = 1'b0;
    bus.conv_avail = 1'b0;
    bus.conv_done = 1'b0;
    repeat (3) tick();
    chk_zero("init");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Reset in the middle of a fill
    bus.ld_req = 1'b1;
    tick();
    chk("mid_grant", int'(bus.ld_grant), 1);
    bus.ld_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_q.push_back('{bank: 0, adr: i});
      bus.ld_wr = 1'b1;
      tick();
      bus.ld_wr = 1'b0;
    end
    chk("mid_adr20", int'(bus.ld_adr), 20);
    chk("mid_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single frame, last avail coincident with done
    do_fill(0, 1'b0, last);
    push_start(last + 2, 0);
    wait_start();
    chk("single_busy_conv", int'(bus.busy), 1);
    run_conv(NOUT, 1'b1, d);
    chk("single_frame", int'(bus.frame_cnt), 1);
    chk("single_err", int'(bus.cnt_err), 0);
    chk("single_busy", int'(bus.busy), 0);

    // Ping-pong overlap
    do_reset();
    do_fill(0, 1'b0, last);
    push_start(last + 2, 0);
    wait_start();
    do_fill(1, 1'b1, last);
    chk("pp_busy", int'(bus.busy), 1);
    run_conv(NOUT, 1'b0, d);
    push_start(d + 2, 1);
    wait_start();
    run_conv(NOUT, 1'b0, d);
    chk("pp_frame", int'(bus.frame_cnt), 2);
    chk("pp_err", int'(bus.cnt_err), 0);
    chk("pp_busy_end", int'(bus.busy), 0);

    // Both banks full: grant held off until bank 0 is freed
    do_reset();
    do_fill(0, 1'b0, last);
    push_start(last + 2, 0);
    wait_start();
    do_fill(1, 1'b0, last);
    bus.ld_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_hold_grant", int'(bus.ld_grant), 0);
    end
    run_conv(NOUT, 1'b0, d);
    chk("full_grant_d1", int'(bus.ld_grant), 0);
    push_start(d + 2, 1);
    tick();
    chk("full_grant_d2", int'(bus.ld_grant), 1);
    chk("full_grant_bank", int'(bus.ld_bank), 0);
    bus.ld_req = 1'b0;

    // Count error is sticky across a good frame
    do_reset();
    do_fill(0, 1'b0, last);
    push_start(last + 2, 0);
    wait_start();
    run_conv(NOUT - 1, 1'b0, d);
    chk("err_set", int'(bus.cnt_err), 1);
    chk("err_frame1", int'(bus.frame_cnt), 1);
    do_fill(1, 1'b0, last);
    push_start(last + 2, 1);
    wait_start();
    run_conv(NOUT, 1'b0, d);
    chk("err_sticky", int'(bus.cnt_err), 1);
    chk("err_frame2", int'(bus.frame_cnt), 2);

    // Ignored strobes outside grant / run
    do_reset();
    bus.ld_wr = 1'b1;
    bus.conv_avail = 1'b1;
    bus.conv_done = 1'b1;
    repeat (3) tick();
    bus.ld_wr = 1'b0;
    bus.conv_avail = 1'b0;
    bus.conv_done = 1'b0;
    tick();
    chk_zero("ignored");
    do_fill(0, 1'b0, last);
    push_start(last + 2, 0);
    bus.ld_wr = 1'b1;
    tick();
    bus.ld_wr = 1'b0;
    wait_start();
    run_conv(NOUT, 1'b0, d);
    chk("ign_err", int'(bus.cnt_err), 0);
    chk("ign_frame", int'(bus.frame_cnt), 1);

    // Frame counter wrap
    for (int f = 2; f <= 256; f++) begin
      bank = (f - 1) % 2;
      do_fill(bank, 1'b0, last);
      push_start(last + 2, bank);
      wait_start();
      run_conv(NOUT, 1'b0, d);
      if (f == 255) chk("frame_255", int'(bus.frame_cnt), 255);
    end
    chk("frame_wrap", int'(bus.frame_cnt), 0);
    chk("wrap_err", int'(bus.cnt_err), 0);

    tick();
    chk("end_wr_q", wr_q.size(), 0);
    chk("end_start_q", start_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_pingpong_sched.md
# conv_pingpong_sched

Frame scheduler for the 3x3 convolution engine. It owns two P×P input image banks (bank 0/1), grants the pixel loader write access to an empty bank, and starts the convolution controller on a full bank. Loading of frame n+1 therefore overlaps convolution of frame n. It also counts the `avail` strobes per frame, checks the output count, and counts completed frames.

## Interface
- `P`, default 8: image width/height in pixels; must be ≥ 3.
- `M`, default 7: address/counter width; 2^M must exceed P*P-1.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `ld_req` input 1: loader has a frame to write.
- `ld_wr` input 1: loader writes one pixel this cycle.
- `ld_grant` output 1: loader owns bank `ld_bank`.
- `ld_bank` output 1: bank being filled.
- `ld_adr` output M: pixel address for the current `ld_wr`, 0..P*P-1.
- `conv_start` output 1: one-cycle start pulse to the convolution controller.
- `conv_bank` output 1: bank the convolution controller reads.
- `conv_avail` input 1: output-pixel strobe from the convolution controller.
- `conv_done` input 1: one-cycle end-of-frame pulse from the convolution controller.
- `busy` output 1: any bank not EMPTY.
- `cnt_err` output 1: sticky; a frame finished with the wrong output count.
- `frame_cnt` output 8: completed frames, wraps 255→0.

## Operation
- Bank status, per bank, 2 bits: EMPTY, FILLING, FULL, CONV.
- Pointers: `wr_ptr` is the next bank to fill; `rd_ptr` is the next bank to convolve. Both reset to 0 and toggle only as described below.
- Fill FSM:
  - F_IDLE → F_FILL when `ld_req`=1 and `status[wr_ptr]`=EMPTY. The bank becomes FILLING and the address counter clears to 0.
  - In F_FILL, `ld_grant`=1, `ld_bank`=`wr_ptr`, `ld_adr`=address counter.
  - Each `ld_wr` increments the counter.
  - An `ld_wr` while `ld_adr`=P*P-1 sets the bank to FULL, toggles `wr_ptr`, clears the counter, and returns the FSM to F_IDLE.
  - `ld_wr` in F_IDLE is ignored.
  - `ld_req` deasserting mid-fill does not abort the fill; the grant holds.
- Conv FSM:
  - C_IDLE → C_START when `status[rd_ptr]`=FULL. The bank becomes CONV and the output counter clears.
  - C_START → C_RUN unconditionally. `conv_start`=1 only while in C_START.
  - In C_RUN, each `conv_avail` increments the output counter, which saturates at 2^M-1.
  - `conv_done` in C_RUN does all of the following:
    - sets the bank to EMPTY;
    - toggles `rd_ptr`;
    - increments `frame_cnt`;
    - sets `cnt_err` if the output count, including a `conv_avail` in the same cycle, ≠ (P-2)^2;
    - returns the FSM to C_IDLE.
  - `conv_done` or `conv_avail` outside C_RUN is ignored.
- `conv_bank` equals `rd_ptr` and is held stable from C_START through C_RUN.
- `busy` is the OR of (status ≠ EMPTY) over both banks.
- Arithmetic is unsigned, M bits. Compare constants P*P-1 and (P-2)^2 are truncated to M bits.

## Timing
- Reset values: all outputs 0, both banks EMPTY, both pointers 0, both FSMs idle, all counters 0, `cnt_err` cleared.
  - Reset asserted mid-frame aborts immediately with no completion pulse.
  - The first grant after reset release follows the `ld_req` rule.
- Grant latency: `ld_req` sampled high in cycle t (bank EMPTY) gives `ld_grant`=1 from cycle t+1.
- Fill length: exactly P*P `ld_wr` pulses. Gaps between them are allowed.
- Fill-to-start latency: last `ld_wr` in cycle t gives bank FULL at t+1 and `conv_start` in cycle t+2.
- Back-to-back frames: `conv_done` in cycle t gives C_IDLE at t+1. If the other bank is FULL at t+1, `conv_start` is in t+2.
- Same-cycle events and priority:
  - `conv_done` freeing a bank while `ld_req` waits: the grant is given in the cycle after the bank reads EMPTY, so there is no combinational pass-through.
  - Fill completion and `conv_done` in the same cycle both take effect, because they act on different banks.
- Both banks full: `ld_grant` stays 0 until a `conv_done` frees `status[wr_ptr]`. No write is lost, because a new fill starts only on an EMPTY bank.

## Test plan
- Reset with P=8: pulse `rst` low mid-fill at `ld_adr`=20 → all outputs 0 and the next `ld_req` grants bank 0 at address 0.
- Single frame: `ld_req`=1, 64 consecutive `ld_wr` → `ld_adr` runs 0..63 and `conv_start` pulses 2 cycles after the 64th write on `conv_bank`=0. Then 36 `conv_avail` plus `conv_done` → `frame_cnt`=1, `cnt_err`=0, `busy`=0.
- Ping-pong overlap: fill bank 0; while bank 0 is in CONV, fill bank 1 (`ld_bank`=1). `conv_done` for bank 0 → `conv_start` with `conv_bank`=1 exactly 2 cycles later.
- Both banks full: fill 0 and 1 and hold `ld_req`=1 → `ld_grant` stays 0. On bank 0's `conv_done`, `ld_grant` rises with `ld_bank`=0 within 2 cycles.
- Count error: 35 `conv_avail` then `conv_done` → `cnt_err`=1 and it stays 1 through a following correct frame of 36.
- Ignored strobes: `ld_wr` with no grant, and `conv_done`/`conv_avail` in C_IDLE → no change to any counter or status. `frame_cnt` at 255 plus one frame → 0.
